// File: rtl/cpu_pkg.sv
// Shared register-file constants for the pipeline control blocks.
package cpu_pkg;

    localparam int NUM_REGISTERS           = 32;
    localparam int MAX_INFLIGHT            = 3;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

    typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;

endpackage

// File: rtl/scoreboard_counter.sv
// Pending-write counter for one architectural register: +1 on issue, -1 per retire/cancel hit.
// Registered count; a decrement below zero clamps to 0 and raises underflow for the same cycle.
module scoreboard_counter
    import cpu_pkg::*;
#(
    parameter int COUNT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   retire_hit,
    input  logic                   cancel_hit,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] count_next,
    output logic                   busy,
    output logic                   underflow
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [COUNT_WIDTH:0]   avail;
    logic [COUNT_WIDTH:0]   dec;

    // One extra bit so count+inc and the two decrements never wrap before comparing.
    always_comb begin
        avail     = {1'b0, count_q} + {{COUNT_WIDTH{1'b0}}, inc};
        dec       = {{COUNT_WIDTH{1'b0}}, retire_hit} + {{COUNT_WIDTH{1'b0}}, cancel_hit};
        underflow = (dec > avail);
        count_d   = underflow ? '0 : COUNT_WIDTH'(avail - dec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign busy       = (count_q != '0);

endmodule

// File: rtl/register_scoreboard.sv
// Issue/retire register scoreboard: grants issue when no source is pending and rd has headroom.
// issue_ready is combinational from registered counters; busy/total/error update one cycle after an event.
module register_scoreboard
    import cpu_pkg::*;
#(
    parameter int  NUM_REGISTERS           = cpu_pkg::NUM_REGISTERS,
    parameter int  MAX_INFLIGHT            = cpu_pkg::MAX_INFLIGHT,
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
    localparam int COUNT_WIDTH             = $clog2(MAX_INFLIGHT + 1),
    localparam int TOTAL_WIDTH             = $clog2(NUM_REGISTERS * MAX_INFLIGHT + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rs1,
    input  logic                               issue_rs1_used,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rs2,
    input  logic                               issue_rs2_used,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rd,
    input  logic                               issue_rd_valid,
    input  logic                               retire_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] retire_rd,
    input  logic                               cancel_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] cancel_rd,
    output logic [NUM_REGISTERS-1:0]           busy,
    output logic [TOTAL_WIDTH-1:0]             inflight_total,
    output logic                               error
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MAX_INFLIGHT);

    logic [COUNT_WIDTH-1:0]   count      [NUM_REGISTERS];
    logic [COUNT_WIDTH-1:0]   count_next [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] busy_vec;
    logic [NUM_REGISTERS-1:0] underflow_vec;

    logic raw1;
    logic raw2;
    logic full;
    logic issue_fire;

    logic                   error_d;
    logic                   error_q;
    logic [TOTAL_WIDTH-1:0] total_d;
    logic [TOTAL_WIDTH-1:0] total_q;

    // x0 has no counter: it can never be busy, full or underflow.
    assign count[0]         = '0;
    assign count_next[0]    = '0;
    assign busy_vec[0]      = 1'b0;
    assign underflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGISTERS; i++) begin : g_cnt
        scoreboard_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (issue_fire && issue_rd_valid &&
                         (issue_rd == REGISTER_INDEXING_WIDTH'(i))),
            .retire_hit (retire_valid && (retire_rd == REGISTER_INDEXING_WIDTH'(i))),
            .cancel_hit (cancel_valid && (cancel_rd == REGISTER_INDEXING_WIDTH'(i))),
            .count      (count[i]),
            .count_next (count_next[i]),
            .busy       (busy_vec[i]),
            .underflow  (underflow_vec[i])
        );
    end

    // No retire bypass: a write retiring this cycle still blocks its readers until next cycle.
    always_comb begin
        raw1        = issue_rs1_used && (issue_rs1 != '0) && busy_vec[issue_rs1];
        raw2        = issue_rs2_used && (issue_rs2 != '0) && busy_vec[issue_rs2];
        full        = issue_rd_valid && (issue_rd != '0) && (count[issue_rd] == COUNT_MAX);
        issue_ready = rst && !(raw1 || raw2 || full);
        issue_fire  = issue_valid && issue_ready;
    end

    always_comb begin
        total_d = '0;
        for (int i = 1; i < NUM_REGISTERS; i++) begin
            total_d = total_d + TOTAL_WIDTH'(count_next[i]);
        end
        error_d = error_q || (|underflow_vec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q <= 1'b0;
            total_q <= '0;
        end else begin
            error_q <= error_d;
            total_q <= total_d;
        end
    end

    assign busy           = busy_vec;
    assign inflight_total = total_q;
    assign error          = error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Scenario tasks plus a randomized run, all checked against a per-register pending-write model.
module tb_register_scoreboard;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    reg_index_t issue_rs1;
    logic       issue_rs1_used;
    reg_index_t issue_rs2;
    logic       issue_rs2_used;
    reg_index_t issue_rd;
    logic       issue_rd_valid;
    logic       retire_valid;
    reg_index_t retire_rd;
    logic       cancel_valid;
    reg_index_t cancel_rd;
    logic [31:0] busy;
    logic [6:0]  inflight_total;
    logic        error;

    int n_checks = 0;
    int n_bad    = 0;

    int cnt [32];
    bit err_m;

    register_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_rd_valid (issue_rd_valid),
        .retire_valid   (retire_valid),
        .retire_rd      (retire_rd),
        .cancel_valid   (cancel_valid),
        .cancel_rd      (cancel_rd),
        .busy           (busy),
        .inflight_total (inflight_total),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        err_m = 1'b0;
    endtask

    function automatic bit model_ready();
        bit hz = 1'b0;
        if (issue_rs1_used && issue_rs1 != 0 && cnt[issue_rs1] > 0) hz = 1'b1;
        if (issue_rs2_used && issue_rs2 != 0 && cnt[issue_rs2] > 0) hz = 1'b1;
        if (issue_rd_valid && issue_rd != 0 && cnt[issue_rd] >= 3) hz = 1'b1;
        return rst && !hz;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (cnt[i] > 0);
        return b;
    endfunction

    function automatic logic [6:0] model_total();
        int s = 0;
        for (int i = 1; i < 32; i++) s += cnt[i];
        return 7'(s);
    endfunction

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rs1      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2      = '0;
        issue_rs2_used = 1'b0;
        issue_rd       = '0;
        issue_rd_valid = 1'b0;
        retire_valid   = 1'b0;
        retire_rd      = '0;
        cancel_valid   = 1'b0;
        cancel_rd      = '0;
    endtask

    task automatic offer(input int rd, input bit rd_v, input int rs1, input bit rs1_v);
        issue_valid    = 1'b1;
        issue_rd       = reg_index_t'(rd);
        issue_rd_valid = rd_v;
        issue_rs1      = reg_index_t'(rs1);
        issue_rs1_used = rs1_v;
        issue_rs2      = '0;
        issue_rs2_used = 1'b0;
    endtask

    // Apply the pending-write rules to the model across one rising edge; returns at the falling edge.
    task automatic tick();
        int  nxt [32];
        bit  fire;
        bit  e = err_m;
        fire = issue_valid && model_ready();
        for (int i = 0; i < 32; i++) nxt[i] = 0;
        for (int i = 1; i < 32; i++) begin
            int d = int'(retire_valid && retire_rd == i) + int'(cancel_valid && cancel_rd == i);
            int n = cnt[i] + int'(fire && issue_rd_valid && issue_rd == i) - d;
            if (n < 0) begin
                n = 0;
                e = 1'b1;
            end
            nxt[i] = n;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt[i] = nxt[i];
            err_m = e;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 32'h0 || inflight_total !== 7'd0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%h total=%0d err=%b want 0/0/0", busy, inflight_total, error);
        end
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_low: got %b want 0", issue_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", issue_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_raw();
        offer(5, 1'b1, 0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (busy[5] !== 1'b1 || inflight_total !== 7'd1) begin
            n_bad++;
            $display("FAIL raw_issue5: busy5=%b total=%0d want 1/1", busy[5], inflight_total);
        end
        offer(0, 1'b0, 5, 1'b1);
        retire_valid = 1'b1;
        retire_rd    = 5'd5;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_no_bypass: ready=%b want 0", issue_ready);
        end
        tick();
        retire_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || busy[5] !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_after_retire: ready=%b busy5=%b want 1/0", issue_ready, busy[5]);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            offer(7, 1'b1, 0, 1'b0);
            tick();
        end
        offer(7, 1'b1, 0, 1'b0);
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_block: ready=%b want 0 total=%0d", issue_ready, inflight_total);
        end
        retire_valid = 1'b1;
        retire_rd    = 5'd7;
        tick();
        retire_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || inflight_total !== 7'd2 || cnt[7] != 2) begin
            n_bad++;
            $display("FAIL full_headroom: ready=%b total=%0d want 1/2", issue_ready, inflight_total);
        end
        idle();
        retire_valid = 1'b1;
        retire_rd    = 5'd7;
        repeat (2) tick();
        idle();
        n_checks++;
        if (busy !== 32'h0 || inflight_total !== 7'd0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drain: busy=%h total=%0d err=%b want 0/0/0", busy, inflight_total, error);
        end
    endtask

    task automatic test_same_cycle();
        offer(9, 1'b1, 0, 1'b0);
        tick();
        offer(9, 1'b1, 0, 1'b0);
        retire_valid = 1'b1;
        retire_rd    = 5'd9;
        tick();
        idle();
        n_checks++;
        if (busy[9] !== 1'b1 || inflight_total !== 7'd1) begin
            n_bad++;
            $display("FAIL issue_retire_same: busy9=%b total=%0d want 1/1", busy[9], inflight_total);
        end
        offer(9, 1'b1, 0, 1'b0);
        tick();
        idle();
        retire_valid = 1'b1;
        retire_rd    = 5'd9;
        cancel_valid = 1'b1;
        cancel_rd    = 5'd9;
        tick();
        idle();
        n_checks++;
        if (busy[9] !== 1'b0 || inflight_total !== 7'd0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL double_dec: busy9=%b total=%0d err=%b want 0/0/0", busy[9], inflight_total, error);
        end
    endtask

    task automatic test_x0();
        for (int k = 0; k < 4; k++) begin
            offer(0, 1'b1, 0, 1'b1);
            issue_rs2_used = 1'b1;
            #1;
            n_checks++;
            if (issue_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL x0_ready: iter=%0d ready=%b want 1", k, issue_ready);
            end
            tick();
        end
        offer(0, 1'b0, 0, 1'b0);
        issue_valid  = 1'b0;
        retire_valid = 1'b1;
        cancel_valid = 1'b1;
        tick();
        idle();
        n_checks++;
        if (busy !== 32'h0 || inflight_total !== 7'd0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_ignored: busy=%h total=%0d err=%b want 0/0/0", busy, inflight_total, error);
        end
    endtask

    task automatic test_async_reset();
        offer(3, 1'b1, 0, 1'b0); tick();
        offer(4, 1'b1, 0, 1'b0); tick();
        offer(8, 1'b1, 0, 1'b0); tick();
        idle();
        n_checks++;
        if (busy !== 32'h0000_0118 || inflight_total !== 7'd3) begin
            n_bad++;
            $display("FAIL async_pre: busy=%h total=%0d want 00000118/3", busy, inflight_total);
        end
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (busy !== 32'h0 || inflight_total !== 7'd0) begin
            n_bad++;
            $display("FAIL async_assert: busy=%h total=%0d want 0/0", busy, inflight_total);
        end
        @(negedge clk);
        rst = 1'b1;
        offer(10, 1'b1, 3, 1'b1);
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_release_ready: ready=%b want 1", issue_ready);
        end
        tick();
        idle();
        n_checks++;
        if (busy !== 32'h0000_0400 || inflight_total !== 7'd1) begin
            n_bad++;
            $display("FAIL async_release_issue: busy=%h total=%0d want 00000400/1", busy, inflight_total);
        end
    endtask

    task automatic test_underflow();
        retire_valid = 1'b1;
        retire_rd    = 5'd12;
        tick();
        idle();
        n_checks++;
        if (error !== 1'b1 || busy[12] !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_set: err=%b busy12=%b want 1/0", error, busy[12]);
        end
        offer(2, 1'b1, 0, 1'b0); tick();
        idle();
        retire_valid = 1'b1;
        retire_rd    = 5'd2;
        tick();
        idle();
        n_checks++;
        if (error !== 1'b1 || inflight_total !== model_total()) begin
            n_bad++;
            $display("FAIL underflow_sticky: err=%b total=%0d want 1/%0d", error, inflight_total, model_total());
        end
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_reset_clear: err=%b want 0", error);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rd       = reg_index_t'($urandom_range(0, 6));
            issue_rd_valid = ($urandom_range(0, 4) != 0);
            issue_rs1      = reg_index_t'($urandom_range(0, 6));
            issue_rs1_used = ($urandom_range(0, 2) == 0);
            issue_rs2      = reg_index_t'($urandom_range(0, 6));
            issue_rs2_used = ($urandom_range(0, 3) == 0);
            retire_valid   = ($urandom_range(0, 2) == 0);
            retire_rd      = reg_index_t'($urandom_range(0, 6));
            cancel_valid   = ($urandom_range(0, 6) == 0);
            cancel_rd      = reg_index_t'($urandom_range(0, 6));
            #1;
            n_checks++;
            if (issue_ready !== model_ready()) begin
                n_bad++;
                $display("FAIL rand_ready: cyc=%0d got %b want %b", k, issue_ready, model_ready());
            end
            tick();
            n_checks++;
            if (busy !== model_busy() || inflight_total !== model_total() || error !== err_m) begin
                n_bad++;
                $display("FAIL rand_state: cyc=%0d busy=%h total=%0d err=%b want %h/%0d/%b",
                         k, busy, inflight_total, error, model_busy(), model_total(), err_m);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_full();
        test_same_cycle();
        test_x0();
        test_async_reset();
        test_underflow();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
